// File: rtl/rvfi_commit_serializer.sv
// Serializes multi-port RVFI commit records into a single stamped valid/ready stream.
// Optional: define RVFI_SERIALIZER_ECALL_HALT_EN to halt the stream after an ecall retires.

package rvfi_pkg;
    typedef struct packed {
        logic        valid;
        logic        trap;
        logic        intr;
        logic [31:0] insn;
        logic [31:0] pc_rdata;
        logic [31:0] pc_wdata;
        logic [4:0]  rd_addr;
        logic [31:0] rd_wdata;
    } rvfi_instr_t;
endpackage

module rvfi_commit_serializer #(
    parameter int unsigned NR_COMMIT_PORTS = 2,
    parameter int unsigned DEPTH           = 8
) (
    input  logic                                         clk_i,
    input  logic                                         rst_i,
    input  rvfi_pkg::rvfi_instr_t [NR_COMMIT_PORTS-1:0]  rvfi_i,
    output logic                                         stall_o,
    output rvfi_pkg::rvfi_instr_t                        rvfi_o,
    output logic [63:0]                                  order_o,
    output logic                                         rvfi_valid_o,
    input  logic                                         rvfi_ready_i,
    output logic [63:0]                                  retired_cnt_o,
    output logic                                         overflow_o,
    output logic                                         halt_o
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] NR_C    = CW'(NR_COMMIT_PORTS);

    rvfi_pkg::rvfi_instr_t mem_q    [DEPTH];
    logic [63:0]           ordMem_q [DEPTH];

    logic [PW-1:0] wrPtr_q, wrPtr_d, rdPtr_q, rdPtr_d;
    logic [CW-1:0] count_q, count_d;
    logic [63:0]   order_q, order_d;
    logic [63:0]   retired_q, retired_d;
    logic          overflow_q, overflow_d;

    logic                         halt;
    logic                         pop;
    logic [CW-1:0]                capacity;
    logic [CW-1:0]                accCnt;
    logic                         dropAny;
    logic [NR_COMMIT_PORTS-1:0]   wrEn;
    logic [PW-1:0]                wrAddr  [NR_COMMIT_PORTS];
    logic [63:0]                  wrOrder [NR_COMMIT_PORTS];
    rvfi_pkg::rvfi_instr_t        headRec;

    assign headRec      = mem_q[rdPtr_q];
    assign rvfi_valid_o = (count_q != '0) && !halt;
    assign pop          = rvfi_valid_o && rvfi_ready_i;
    assign rvfi_o       = rvfi_valid_o ? headRec : '0;
    assign order_o      = rvfi_valid_o ? ordMem_q[rdPtr_q] : 64'd0;
    assign stall_o      = !halt && ((DEPTH_C - count_q) < NR_C);
    assign capacity     = DEPTH_C - count_q + {{(CW-1){1'b0}}, pop};

    // Compact live slots in port order; only valid records consume a stamp,
    // trap-only records borrow the stamp the next valid record will get.
    always_comb begin
        accCnt  = '0;
        order_d = order_q;
        dropAny = 1'b0;
        wrEn    = '0;
        for (int p = 0; p < NR_COMMIT_PORTS; p++) begin
            wrAddr[p]  = wrPtr_q + accCnt[PW-1:0];
            wrOrder[p] = order_d;
            if ((rvfi_i[p].valid || rvfi_i[p].trap) && !halt) begin
                if (accCnt < capacity) begin
                    wrEn[p] = 1'b1;
                    accCnt  = accCnt + CW'(1);
                    if (rvfi_i[p].valid) begin
                        order_d = order_d + 64'd1;
                    end
                end else begin
                    dropAny = 1'b1;
                end
            end
        end
    end

    always_comb begin
        wrPtr_d    = wrPtr_q + accCnt[PW-1:0];
        rdPtr_d    = rdPtr_q + {{(PW-1){1'b0}}, pop};
        count_d    = count_q + accCnt - {{(CW-1){1'b0}}, pop};
        retired_d  = retired_q + {63'd0, pop && headRec.valid};
        overflow_d = overflow_q || dropAny;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wrPtr_q    <= '0;
            rdPtr_q    <= '0;
            count_q    <= '0;
            order_q    <= 64'd0;
            retired_q  <= 64'd0;
            overflow_q <= 1'b0;
        end else begin
            wrPtr_q    <= wrPtr_d;
            rdPtr_q    <= rdPtr_d;
            count_q    <= count_d;
            order_q    <= order_d;
            retired_q  <= retired_d;
            overflow_q <= overflow_d;
        end
    end

    // Storage needs no reset: the head is masked whenever the FIFO is empty.
    always_ff @(posedge clk_i) begin
        for (int p = 0; p < NR_COMMIT_PORTS; p++) begin
            if (wrEn[p]) begin
                mem_q[wrAddr[p]]    <= rvfi_i[p];
                ordMem_q[wrAddr[p]] <= wrOrder[p];
            end
        end
    end

`ifdef RVFI_SERIALIZER_ECALL_HALT_EN
    logic halt_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            halt_q <= 1'b0;
        end else if (pop && headRec.valid && (headRec.insn == 32'h0000_0073)) begin
            halt_q <= 1'b1;
        end
    end

    assign halt = halt_q;
`else
    assign halt = 1'b0;
`endif

    assign halt_o        = halt;
    assign retired_cnt_o = retired_q;
    assign overflow_o    = overflow_q;

endmodule

// File: tb/tb_rvfi_commit_serializer.sv
// Scoreboard bench for rvfi_commit_serializer: directed commit patterns, monitor-side comparison.

module tb_rvfi_commit_serializer;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] insn;
        logic        valid;
        logic        trap;
        logic [63:0] order;
    } exp_t;

    logic                                 clk;
    logic                                 rst;
    rvfi_pkg::rvfi_instr_t [1:0]          rvfiIn;
    logic                                 stall;
    rvfi_pkg::rvfi_instr_t                rvfiOut;
    logic [63:0]                          orderOut;
    logic                                 rvfiValid;
    logic                                 rvfiReady;
    logic [63:0]                          retiredCnt;
    logic                                 overflow;
    logic                                 halt;

    exp_t sbQ [$];
    int   checkCount = 0;
    int   passCount  = 0;

    rvfi_commit_serializer #(.NR_COMMIT_PORTS(2), .DEPTH(8)) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .rvfi_i        (rvfiIn),
        .stall_o       (stall),
        .rvfi_o        (rvfiOut),
        .order_o       (orderOut),
        .rvfi_valid_o  (rvfiValid),
        .rvfi_ready_i  (rvfiReady),
        .retired_cnt_o (retiredCnt),
        .overflow_o    (overflow),
        .halt_o        (halt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checkCount++;
        if (actual === expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    function automatic rvfi_pkg::rvfi_instr_t mkRec(input logic v, input logic t,
                                                    input logic [31:0] pc, input logic [31:0] insn);
        rvfi_pkg::rvfi_instr_t r;
        r          = '0;
        r.valid    = v;
        r.trap     = t;
        r.pc_rdata = pc;
        r.pc_wdata = pc + 32'd4;
        r.insn     = insn;
        return r;
    endfunction

    task automatic expectRecord(input logic [31:0] pc, input logic [31:0] insn,
                                input logic v, input logic t, input logic [63:0] order);
        exp_t e;
        e.pc = pc; e.insn = insn; e.valid = v; e.trap = t; e.order = order;
        sbQ.push_back(e);
    endtask

    // Drive one cycle of commit input, then return to idle just after the edge.
    task automatic applyStimulus(input rvfi_pkg::rvfi_instr_t p0, input rvfi_pkg::rvfi_instr_t p1,
                                 input logic ready);
        rvfiIn[0] = p0;
        rvfiIn[1] = p1;
        rvfiReady = ready;
        @(posedge clk);
        #1;
        rvfiIn    = '0;
    endtask

    task automatic resetDut();
        rst       = 1'b1;
        rvfiIn    = '0;
        rvfiReady = 1'b0;
        sbQ.delete();
        #1;
        checkOutput("reset valid",    {63'd0, rvfiValid}, 64'd0);
        checkOutput("reset retired",  retiredCnt,         64'd0);
        checkOutput("reset overflow", {63'd0, overflow},  64'd0);
        checkOutput("reset order",    orderOut,           64'd0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic waitDrain(input int budget);
        int n;
        n = 0;
        rvfiReady = 1'b1;
        while ((sbQ.size() != 0 || rvfiValid) && n < budget) begin
            @(posedge clk);
            #1;
            n++;
        end
        checkOutput("drain scoreboard empty", 64'(sbQ.size()), 64'd0);
    endtask

    // Monitor: a pop happens at the next edge whenever valid and ready are both high.
    always @(negedge clk) begin
        if (!rst && rvfiValid && rvfiReady) begin
            if (sbQ.size() == 0) begin
                checkOutput("unexpected record pc", {32'd0, rvfiOut.pc_rdata}, 64'hFFFF_FFFF_FFFF_FFFF);
            end else begin
                exp_t e;
                e = sbQ.pop_front();
                checkOutput("record pc",    {32'd0, rvfiOut.pc_rdata}, {32'd0, e.pc});
                checkOutput("record insn",  {32'd0, rvfiOut.insn},     {32'd0, e.insn});
                checkOutput("record flags", {62'd0, rvfiOut.valid, rvfiOut.trap}, {62'd0, e.valid, e.trap});
                checkOutput("record order", orderOut, e.order);
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL global timeout: got running, expected finished");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        rst       = 1'b1;
        rvfiIn    = '0;
        rvfiReady = 1'b0;
        resetDut();

        // Idle after reset
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checkOutput("idle valid",    {63'd0, rvfiValid}, 64'd0);
            checkOutput("idle stall",    {63'd0, stall},     64'd0);
            checkOutput("idle retired",  retiredCnt,         64'd0);
            checkOutput("idle overflow", {63'd0, overflow},  64'd0);
        end
        @(posedge clk);
        #1;

        // Two valid records in one cycle
        expectRecord(32'h8000_0000, 32'h0000_0013, 1'b1, 1'b0, 64'd0);
        expectRecord(32'h8000_0004, 32'h0000_0093, 1'b1, 1'b0, 64'd1);
        applyStimulus(mkRec(1'b1, 1'b0, 32'h8000_0000, 32'h0000_0013),
                      mkRec(1'b1, 1'b0, 32'h8000_0004, 32'h0000_0093), 1'b1);
        @(negedge clk);
        checkOutput("latency head valid", {63'd0, rvfiValid}, 64'd1);
        checkOutput("latency head pc",    {32'd0, rvfiOut.pc_rdata}, 64'h8000_0000);
        @(posedge clk);
        #1;
        waitDrain(20);
        @(negedge clk);
        checkOutput("retired after pair", retiredCnt, 64'd2);
        checkOutput("empty head zero",    {32'd0, rvfiOut.pc_rdata}, 64'd0);

        // Dead port0, then a trap-only record, then a valid one
        resetDut();
        expectRecord(32'h0000_0100, 32'h0000_0013, 1'b1, 1'b0, 64'd0);
        applyStimulus('0, mkRec(1'b1, 1'b0, 32'h0000_0100, 32'h0000_0013), 1'b1);
        expectRecord(32'h0000_0104, 32'h0000_0000, 1'b0, 1'b1, 64'd1);
        applyStimulus(mkRec(1'b0, 1'b1, 32'h0000_0104, 32'h0000_0000), '0, 1'b1);
        expectRecord(32'h0000_0108, 32'h0000_0113, 1'b1, 1'b0, 64'd1);
        applyStimulus(mkRec(1'b1, 1'b0, 32'h0000_0108, 32'h0000_0113), '0, 1'b1);
        waitDrain(20);
        @(negedge clk);
        checkOutput("retired skips trap", retiredCnt, 64'd2);
        checkOutput("no overflow yet",    {63'd0, overflow}, 64'd0);

        // Fill with sink blocked, then overflow
        resetDut();
        for (int c = 0; c < 4; c++) begin
            logic [31:0] base;
            base = 32'h0000_2000 + 32'(c) * 32'd8;
            expectRecord(base,         32'h0000_0013, 1'b1, 1'b0, 64'(2 * c));
            expectRecord(base + 32'd4, 32'h0000_0013, 1'b1, 1'b0, 64'(2 * c + 1));
            applyStimulus(mkRec(1'b1, 1'b0, base, 32'h0000_0013),
                          mkRec(1'b1, 1'b0, base + 32'd4, 32'h0000_0013), 1'b0);
            @(negedge clk);
            checkOutput("fill stall", {63'd0, stall}, (c == 3) ? 64'd1 : 64'd0);
            checkOutput("fill valid", {63'd0, rvfiValid}, 64'd1);
            @(posedge clk);
            #1;
        end
        applyStimulus(mkRec(1'b1, 1'b0, 32'h0000_3000, 32'h0000_0013),
                      mkRec(1'b1, 1'b0, 32'h0000_3004, 32'h0000_0013), 1'b0);
        @(negedge clk);
        checkOutput("full drop overflow", {63'd0, overflow}, 64'd1);
        checkOutput("full head order",    orderOut, 64'd0);
        @(posedge clk);
        #1;

        // Full with pop: only port0 accepted, stamp continues at 8
        expectRecord(32'h0000_4000, 32'h0000_0013, 1'b1, 1'b0, 64'd8);
        applyStimulus(mkRec(1'b1, 1'b0, 32'h0000_4000, 32'h0000_0013),
                      mkRec(1'b1, 1'b0, 32'h0000_4004, 32'h0000_0013), 1'b1);
        rvfiReady = 1'b0;
        @(negedge clk);
        checkOutput("full pop stays full", {63'd0, stall}, 64'd1);
        checkOutput("full pop overflow",   {63'd0, overflow}, 64'd1);
        @(posedge clk);
        #1;
        waitDrain(40);
        @(negedge clk);
        checkOutput("retired after fill", retiredCnt, 64'd9);
        checkOutput("overflow sticky",    {63'd0, overflow}, 64'd1);
        checkOutput("stall after drain",  {63'd0, stall},    64'd0);

        // Ecall behaviour
        resetDut();
        expectRecord(32'h0000_5000, 32'h0000_0073, 1'b1, 1'b0, 64'd0);
`ifndef RVFI_SERIALIZER_ECALL_HALT_EN
        expectRecord(32'h0000_5004, 32'h0000_0013, 1'b1, 1'b0, 64'd1);
`endif
        applyStimulus(mkRec(1'b1, 1'b0, 32'h0000_5000, 32'h0000_0073), '0, 1'b1);
        applyStimulus(mkRec(1'b1, 1'b0, 32'h0000_5004, 32'h0000_0013), '0, 1'b1);
        repeat (4) @(posedge clk);
        @(negedge clk);
`ifdef RVFI_SERIALIZER_ECALL_HALT_EN
        checkOutput("ecall halt",        {63'd0, halt},      64'd1);
        checkOutput("halted valid",      {63'd0, rvfiValid}, 64'd0);
        checkOutput("halted retired",    retiredCnt,         64'd1);
        checkOutput("halted stall",      {63'd0, stall},     64'd0);
`else
        checkOutput("ecall no halt",     {63'd0, halt},      64'd0);
        checkOutput("ecall retired",     retiredCnt,         64'd2);
`endif
        checkOutput("ecall scoreboard empty", 64'(sbQ.size()), 64'd0);

        $display("[TB] %0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
